// File: rtl/can_rx_fifo_if.sv
// Bus bundle between the CAN receiver / CPU side and the receive FIFO.
// master = frame source plus CPU register port; slave = the FIFO.
interface can_rx_fifo_if;
  logic        frm_valid;
  logic        frm_ext;
  logic        frm_rtr;
  logic [28:0] frm_id;
  logic [3:0]  frm_dlc;
  logic [63:0] frm_data;
  logic        cs;
  logic        we;
  logic [2:0]  rs;
  logic [31:0] d;
  logic [31:0] q;
  logic        irq;

  modport master (
    output frm_valid, frm_ext, frm_rtr, frm_id, frm_dlc, frm_data,
    output cs, we, rs, d,
    input  q, irq
  );

  modport slave (
    input  frm_valid, frm_ext, frm_rtr, frm_id, frm_dlc, frm_data,
    input  cs, we, rs, d,
    output q, irq
  );
endinterface

// File: rtl/can_rx_fifo.sv
// CAN receive FIFO: ID acceptance filter, DEPTH-entry frame queue, CPU register
// window onto the head frame, explicit pop/flush and a maskable level interrupt.
module can_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic         clk,
  input logic         rst_n,
  can_rx_fifo_if.slave bus
);

  typedef struct packed {
    logic        ext;
    logic        rtr;
    logic [28:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
  } entry_t;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  localparam logic [2:0] RS_HEAD_ID  = 3'd0;
  localparam logic [2:0] RS_HEAD_DLC = 3'd1;
  localparam logic [2:0] RS_HEAD_D0  = 3'd2;
  localparam logic [2:0] RS_HEAD_D1  = 3'd3;
  localparam logic [2:0] RS_FCODE    = 3'd4;
  localparam logic [2:0] RS_FMASK    = 3'd5;
  localparam logic [2:0] RS_CTRL     = 3'd6;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   fcode_q, fcode_d;
  logic [31:0]   fmask_q, fmask_d;
  logic [1:0]    irqen_q, irqen_d;

  logic   ctrl_wr, flush, clr_ovf, pop, push, overflow, accept, full, empty;
  entry_t head;
  logic [31:0] rdata;

  // Decode CPU control strobes, run the acceptance filter and resolve push/pop.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    ctrl_wr  = bus.cs & bus.we & (bus.rs == RS_CTRL);
    flush    = ctrl_wr & bus.d[2];
    clr_ovf  = ctrl_wr & bus.d[1];
    full     = (count_q == DEPTH_C);
    empty    = (count_q == '0);
    pop      = ctrl_wr & bus.d[0] & ~flush & ~empty;
    accept   = (((bus.frm_id ^ fcode_q[28:0]) & fmask_q[28:0]) == '0) &
               (~fmask_q[31] | (bus.frm_ext == fcode_q[31]));
    // A same-cycle pop or flush frees room, so a full FIFO can still take the frame.
    push     = bus.frm_valid & accept & (~full | pop | flush);
    overflow = bus.frm_valid & accept & ~push;
  end

  // Next-state for pointers, count, sticky overflow and CPU-writable registers.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    fcode_d  = fcode_q;
    fmask_d  = fmask_q;
    irqen_d  = irqen_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);

    if (flush) begin
      // The frame pushed alongside a flush becomes the sole entry.
      rd_ptr_d = wr_ptr_q;
      count_d  = push ? (AW+1)'(1) : '0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    // An overflow in the same cycle as CLR_OVF keeps the flag set.
    if (overflow)     ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;

    if (bus.cs && bus.we) begin
      case (bus.rs)
        RS_FCODE: fcode_d = {bus.d[31], 2'b00, bus.d[28:0]};
        RS_FMASK: fmask_d = {bus.d[31], 2'b00, bus.d[28:0]};
        RS_CTRL:  irqen_d = bus.d[5:4];
        default:  ;
      endcase
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      fcode_q  <= '0;
      fmask_q  <= '0;
      irqen_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      fcode_q  <= fcode_d;
      fmask_q  <= fmask_d;
      irqen_q  <= irqen_d;
    end
  end

  // Frame storage: written on accepted push.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; empty entries are never exposed because reads gate on count.
    if (push) begin
      mem_q[wr_ptr_q] <= '{ext:  bus.frm_ext,
                           rtr:  bus.frm_rtr,
                           id:   bus.frm_id,
                           dlc:  bus.frm_dlc,
                           data: bus.frm_data};
    end
  end

  // CPU read mux: combinational, zero when not selected, no side effects.
  always_comb begin
    head  = mem_q[rd_ptr_q];
    rdata = '0;
    if (bus.cs) begin
      case (bus.rs)
        RS_HEAD_ID:  if (!empty) rdata = {head.ext, head.rtr, 1'b0, head.id};
        RS_HEAD_DLC: begin
          rdata[31 -: AW+1] = count_q;
          rdata[4]          = ovf_q;
          if (!empty) rdata[3:0] = head.dlc;
        end
        RS_HEAD_D0:  if (!empty) rdata = head.data[31:0];
        RS_HEAD_D1:  if (!empty) rdata = head.data[63:32];
        RS_FCODE:    rdata = fcode_q;
        RS_FMASK:    rdata = fmask_q;
        RS_CTRL:     rdata[5:4] = irqen_q;
        default:     rdata = '0;
      endcase
    end
  end

  assign bus.q   = rdata;
  assign bus.irq = (irqen_q[0] & ~empty) | (irqen_q[1] & ovf_q);

endmodule
